sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per line, with IMG_W >= 3.
REQ-003 SHALL have parameter IMG_H, default 480, lines per frame, with IMG_H >= 3.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_data is accepted on this cycle; there is no backpressure.
REQ-007 SHALL have port pix_data, input, DATA_W bits: raster-order grayscale pixel.
REQ-008 SHALL have port sof, input, 1 bit: start of frame; qualified by pix_valid, and marks the accepted pixel as row 0, col 0.
REQ-009 SHALL have port win_valid, output, 1 bit: win_data holds a complete 3x3 window.
REQ-010 SHALL have port win_data, output, 9*DATA_W bits: window passed to the downstream Sobel adder tree.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL pack win_data so that slice [DATA_W*(3*r+c) +: DATA_W] is the pixel at row offset r and column offset c; r=0 is the oldest line, c=0 is the leftmost column, and r=2,c=2 is the most recent pixel.
REQ-013 SHALL keep two line buffers, lb0 and lb1, each IMG_W x DATA_W; lb0 holds the previous line and lb1 holds the line before that.
REQ-014 SHALL, on an accepted pixel at column col, write lb0[col] <= pix_data and lb1[col] <= old lb0[col].
REQ-015 SHALL, in the same cycle, shift the 3x3 window registers one column left and load column c=2 with {old lb1[col], old lb0[col], pix_data} for r=0,1,2.
REQ-016 SHALL keep col counter (0..IMG_W-1) and row counter (0..IMG_H-1), both advancing only on accepted pixels.
REQ-017 SHALL wrap col from IMG_W-1 to 0 and increment row at that point.
REQ-018 SHALL wrap row from IMG_H-1 to 0 when col also wraps, i.e. at the end of the frame.
REQ-019 SHALL register win_valid one cycle after acceptance, equal to (row >= 2) && (col >= 2) evaluated for the accepted pixel; latency from pixel to window is 1 cycle.
REQ-020 SHALL deassert win_valid in any cycle following one with pix_valid=0.
REQ-021 SHALL hold win_data, the counters and the line buffers unchanged while pix_valid=0.
REQ-022 SHALL produce no border windows: frame edges yield no output; per frame there are exactly (IMG_W-2)*(IMG_H-2) win_valid pulses.
REQ-023 SHALL pulse frame_done for one cycle, one cycle after acceptance of the pixel at row IMG_H-1, col IMG_W-1.
REQ-024 SHALL treat sof=1 with pix_valid=1 as col=0 and row=0 for that pixel, regardless of counter state, and continue counting from there; a mid-frame sof aborts the current frame and raises no frame_done.
REQ-025 SHALL ignore sof when pix_valid=0.
REQ-026 SHALL NOT require line buffer contents to be cleared; stale data is never exposed because of the row >= 2 gating.

Reset
REQ-027 SHALL, while rst=1, force col=0, row=0, win_valid=0, frame_done=0 and win_data=0 on the next clock edge.
REQ-028 SHALL give rst priority over pix_valid and sof; a pixel presented with rst=1 is dropped.
REQ-029 SHALL, when rst is asserted mid-frame, make the first pixel accepted after reset row 0, col 0.

Verification (IMG_W=4, IMG_H=4, DATA_W=8 unless noted)
REQ-030 SHALL cover: hold rst=1 for 2 cycles with pix_valid=1 -> win_valid=0, frame_done=0, win_data=0.
REQ-031 SHALL cover: send pixels 0..15 back-to-back with sof on pixel 0 -> exactly 4 windows, one cycle after pixels 10, 11, 14 and 15; the first window is {0,1,2,4,5,6,8,9,10}, ordered c=0..2 within r=0..2; frame_done pulses one cycle after pixel 15.
REQ-032 SHALL cover: the same frame with pix_valid dropped for 1-3 random cycles between pixels -> identical window sequence and values, with win_valid never asserted during gaps.
REQ-033 SHALL cover: two back-to-back frames, pixels 0..15 then 100..115, with no rst -> second-frame first window is {100,101,102,104,105,106,108,109,110} and 2 frame_done pulses in total.
REQ-034 SHALL cover: sof reasserted at pixel 7 of a frame -> counters restart, no frame_done for the aborted frame, and the first window comes one cycle after the 11th pixel from the new sof.
REQ-035 SHALL cover: rst asserted for 1 cycle after pixel 9, then a full frame -> 4 windows from the new frame only, with correct values.

Source files
------------

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 sliding window generator with two line buffers for a Sobel filter
module sobel_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_data,
    input  logic                  sof,
    output logic                  win_valid,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [CW-1:0]     eff_col;
    logic [RW-1:0]     eff_row;
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] new_col [3];

    // Position of the pixel being accepted: sof overrides the counters so a frame can restart anywhere
    always_comb begin
        accept     = pix_valid && !rst;
        eff_col    = sof ? '0 : col;
        eff_row    = sof ? '0 : row;
        col_last   = (eff_col == COL_MAX);
        row_last   = (eff_row == ROW_MAX);
        lb0_rd     = lb0[eff_col];
        lb1_rd     = lb1[eff_col];
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = pix_data;
    end

    // Raster counters; they only move on accepted pixels and wrap at line and frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : eff_row + RW'(1);
            end else begin
                col <= eff_col + CW'(1);
                row <= eff_row;
            end
        end
    end

    // Line buffers: the current line pushes the previous one down; contents never need clearing
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[eff_col] <= pix_data;
            lb1[eff_col] <= lb0_rd;
        end
    end

    // Window shift register plus its qualifiers; border positions never raise win_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            win_data   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_data[DATA_W*(3*r+0) +: DATA_W] <= win_data[DATA_W*(3*r+1) +: DATA_W];
                win_data[DATA_W*(3*r+1) +: DATA_W] <= win_data[DATA_W*(3*r+2) +: DATA_W];
                win_data[DATA_W*(3*r+2) +: DATA_W] <= new_col[r];
            end
            win_valid  <= (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
            frame_done <= row_last && col_last;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen against a frame-store model
module tb_sobel_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pix_valid;
    logic [DW-1:0]   pix_data;
    logic            sof;
    logic            win_valid;
    logic [9*DW-1:0] win_data;
    logic            frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the frame as an image, addressed by the position the pixel lands at
    logic [DW-1:0]   frame [H][W];
    int              mcol = 0;
    int              mrow = 0;
    int              pix_idx;
    int              win_count;
    int              done_count;
    logic            have_first;
    logic [9*DW-1:0] first_win;
    int              first_idx;

    sobel_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .sof(sof),
        .win_valid(win_valid),
        .win_data(win_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [9*DW-1:0] make_win(input int base);
        int off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [9*DW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(base + off[k]);
        return w;
    endfunction

    task automatic clear_stats();
        pix_idx    = 0;
        win_count  = 0;
        done_count = 0;
        have_first = 1'b0;
        first_win  = '0;
        first_idx  = -1;
    endtask

    task automatic send(input logic [DW-1:0] px, input logic s);
        logic            ev;
        logic            ed;
        logic [9*DW-1:0] ew;
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b1; pix_data = px; sof = s;
        if (s) begin mcol = 0; mrow = 0; end
        frame[mrow][mcol] = px;
        ev = (mrow >= 2) && (mcol >= 2);
        ed = (mrow == H-1) && (mcol == W-1);
        ew = '0;
        if (ev)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    ew[DW*(3*r+c) +: DW] = frame[mrow-2+r][mcol-2+c];
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (win_valid !== ev) begin
            n_fail++;
            $display("FAIL win_valid pix %0d: got %b expected %b", pix_idx, win_valid, ev);
        end
        if (ev) begin
            n_checks++;
            if (win_data !== ew) begin
                n_fail++;
                $display("FAIL win_data pix %0d: got %h expected %h", pix_idx, win_data, ew);
            end
        end
        n_checks++;
        if (frame_done !== ed) begin
            n_fail++;
            $display("FAIL frame_done pix %0d: got %b expected %b", pix_idx, frame_done, ed);
        end
        if (win_valid === 1'b1) begin
            win_count++;
            if (!have_first) begin
                have_first = 1'b1;
                first_win  = win_data;
                first_idx  = pix_idx;
            end
        end
        if (frame_done === 1'b1) done_count++;
        pix_idx++;
    endtask

    task automatic gap();
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0; pix_data = DW'($urandom); sof = 1'($urandom);
        @(posedge clk); #1;
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL gap outputs: win_valid %b frame_done %b expected 0 0", win_valid, frame_done);
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b1; pix_data = DW'($urandom); sof = 1'($urandom);
        mcol = 0; mrow = 0;
        @(posedge clk); #1;
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: win_valid %b frame_done %b win_data %h expected 0 0 0",
                     win_valid, frame_done, win_data);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset_cycle();
        reset_cycle();
    endtask

    task automatic test_frame();
        clear_stats();
        for (int i = 0; i < 16; i++) send(DW'(i), i == 0);
        check_int("frame window count", win_count, 4);
        check_int("frame done count", done_count, 1);
        check_int("frame first window pixel", first_idx, 10);
        check_win("frame first window", first_win, make_win(0));
    endtask

    task automatic test_gaps();
        clear_stats();
        for (int i = 0; i < 16; i++) begin
            send(DW'(i), i == 0);
            repeat ($urandom_range(1, 3)) gap();
        end
        check_int("gaps window count", win_count, 4);
        check_int("gaps done count", done_count, 1);
        check_win("gaps first window", first_win, make_win(0));
    endtask

    task automatic test_back_to_back();
        clear_stats();
        for (int i = 0; i < 16; i++) send(DW'(i), i == 0);
        have_first = 1'b0;
        for (int i = 0; i < 16; i++) send(DW'(100 + i), 1'b0);
        check_int("b2b window count", win_count, 8);
        check_int("b2b done count", done_count, 2);
        check_int("b2b second first window pixel", first_idx, 26);
        check_win("b2b second first window", first_win, make_win(100));
    endtask

    task automatic test_sof_abort();
        clear_stats();
        for (int i = 0; i < 7; i++) send(DW'(i), i == 0);
        pix_idx = 0;
        for (int i = 0; i < 16; i++) send(DW'(50 + i), i == 0);
        check_int("abort done count", done_count, 1);
        check_int("abort window count", win_count, 4);
        check_int("abort first window pixel", first_idx, 10);
        check_win("abort first window", first_win, make_win(50));
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) send(DW'(i), i == 0);
        reset_cycle();
        clear_stats();
        for (int i = 0; i < 16; i++) send(DW'(200 + i), 1'b0);
        check_int("rst-mid window count", win_count, 4);
        check_int("rst-mid done count", done_count, 1);
        check_win("rst-mid first window", first_win, make_win(200));
    endtask

    task automatic test_random();
        clear_stats();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) begin
                send(DW'($urandom), i == 0);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) gap();
            end
        check_int("random window count", win_count, 8);
        check_int("random done count", done_count, 2);
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; sof = 1'b0;
        clear_stats();
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_sof_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
